cpri_rxbuf_align_ctrl: RTL and testbench

CPRI_RXBUF_ALIGN_CTRL -- requirements
Module: cpri_rxbuf_align_ctrl

---
 rtl/cpri_rx_pkg.sv | 20 ++
 rtl/cpri_skew_counter.sv | 28 ++
 rtl/cpri_rxbuf_align_ctrl.sv | 142 ++++++++++++++
 tb/tb_cpri_rxbuf_align_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpri_rx_pkg.sv
// Shared types and defaults for the CPRI rx buffer alignment controller.
package cpri_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ALL = 2'd1,
    ST_READ     = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  localparam int unsigned SKEW_MAX_DEF = 12672;
  localparam int unsigned CLR_LEN_DEF  = 8;
  localparam int unsigned CNT_W        = 16;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/cpri_skew_counter.sv
// Inter-lane skew counter: clear, saturating increment, overflow compare.
// o_cnt_c / o_ovf_c reflect this cycle's value with a pending clear applied.
module cpri_skew_counter
  import cpri_rx_pkg::*;
#(
  parameter int unsigned SKEW_MAX = SKEW_MAX_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt_c,
  output logic             o_ovf_c
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cur;

  assign w_cur   = i_clr ? '0 : r_cnt;
  assign o_cnt_c = w_cur;
  assign o_ovf_c = 32'(w_cur) > SKEW_MAX;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_cnt <= '0;
    else         r_cnt <= sat_inc(w_cur, i_inc);
  end

endmodule

// File: rtl/cpri_rxbuf_align_ctrl.sv
// CPRI rx buffer alignment controller: waits for all lanes, reads in lockstep,
// flushes on skew overflow / frame resync. Optional SOP check: CPRI_RXBUF_SOP_CHECK_EN.
module cpri_rxbuf_align_ctrl
  import cpri_rx_pkg::*;
#(
  parameter int unsigned LANE     = 8,
  parameter int unsigned SKEW_MAX = SKEW_MAX_DEF,
  parameter int unsigned CLR_LEN  = CLR_LEN_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_rx_rfp,
  input  logic [LANE-1:0]  i_buf_vld,
  input  logic [LANE-1:0]  i_buf_sop,
  output logic             o_rd_en,
  output logic             o_buf_clr,
  output logic             o_skew_err,
  output logic             o_sop_err,
  output logic [CNT_W-1:0] o_skew_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [1:0]       o_state
);

  localparam int unsigned CLR_W = $clog2(CLR_LEN + 1);

  state_t           r_state;
  logic             r_any_d;
  logic             r_buf_clr;
  logic             r_skew_err;
  logic             r_sop_err;
  logic [CNT_W-1:0] r_skew_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CLR_W-1:0] r_clr_idx;

  logic             w_any;
  logic             w_all;
  logic             w_in_wait;
  logic             w_rise;
  logic             w_inc;
  logic             w_ovf;
  logic             w_rd_en;
  logic             w_sop_bad;
  logic [CNT_W-1:0] w_cnt;

  assign w_any     = |i_buf_vld;
  assign w_all     = &i_buf_vld;
  assign w_in_wait = (r_state == ST_WAIT_ALL);
  // r_any_d only remembers WAIT_ALL history, so entering WAIT_ALL with data counts as a rise.
  assign w_rise    = w_in_wait & w_any & ~r_any_d;
  assign w_inc     = w_in_wait & w_any & ~w_all;
  assign w_rd_en   = (r_state == ST_READ) & w_all & i_enable;

`ifdef CPRI_RXBUF_SOP_CHECK_EN
  assign w_sop_bad = w_rd_en & (|i_buf_sop) & ~(&i_buf_sop);
`else
  assign w_sop_bad = 1'b0 & (^i_buf_sop);
`endif

  cpri_skew_counter #(
    .SKEW_MAX (SKEW_MAX)
  ) u_skew_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_rise),
    .i_inc   (w_inc),
    .o_cnt_c (w_cnt),
    .o_ovf_c (w_ovf)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_any_d     <= 1'b0;
      r_buf_clr   <= 1'b0;
      r_skew_err  <= 1'b0;
      r_sop_err   <= 1'b0;
      r_skew_cnt  <= '0;
      r_flush_cnt <= '0;
      r_clr_idx   <= '0;
    end else begin
      r_any_d <= w_in_wait & w_any;
      unique case (r_state)
        ST_IDLE: begin
          if (i_enable) begin
            r_state    <= ST_WAIT_ALL;
            r_skew_err <= 1'b0;
            r_sop_err  <= 1'b0;
          end
        end
        ST_WAIT_ALL: begin
          if (!i_enable) begin
            r_state <= ST_IDLE;
          end else if (i_rx_rfp || w_ovf) begin
            r_state     <= ST_FLUSH;
            r_buf_clr   <= 1'b1;
            r_clr_idx   <= '0;
            r_flush_cnt <= sat_inc(r_flush_cnt, 1'b1);
            if (w_ovf) r_skew_err <= 1'b1;
          end else if (w_all) begin
            r_state    <= ST_READ;
            r_skew_cnt <= w_cnt;
          end
        end
        ST_READ: begin
          if (!i_enable) begin
            r_state <= ST_IDLE;
          end else if (i_rx_rfp || w_sop_bad) begin
            r_state     <= ST_FLUSH;
            r_buf_clr   <= 1'b1;
            r_clr_idx   <= '0;
            r_flush_cnt <= sat_inc(r_flush_cnt, 1'b1);
            if (w_sop_bad) r_sop_err <= 1'b1;
          end else if (!w_all) begin
            r_state <= ST_WAIT_ALL;
          end
        end
        ST_FLUSH: begin
          // A frame pulse makes the current cycle index 0 of a fresh clear window.
          if (i_rx_rfp) begin
            r_clr_idx <= CLR_W'(1);
          end else if (r_clr_idx >= CLR_W'(CLR_LEN - 1)) begin
            r_state   <= ST_IDLE;
            r_buf_clr <= 1'b0;
          end else begin
            r_clr_idx <= r_clr_idx + CLR_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rd_en     = w_rd_en;
  assign o_buf_clr   = r_buf_clr;
  assign o_skew_err  = r_skew_err;
  assign o_sop_err   = r_sop_err;
  assign o_skew_cnt  = r_skew_cnt;
  assign o_flush_cnt = r_flush_cnt;
  assign o_state     = r_state;

endmodule

// File: tb/tb_cpri_rxbuf_align_ctrl.sv
// Directed self-checking bench for cpri_rxbuf_align_ctrl (default parameters).
module tb_cpri_rxbuf_align_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        i_rx_rfp;
  logic [7:0]  i_buf_vld;
  logic [7:0]  i_buf_sop;
  logic        o_rd_en;
  logic        o_buf_clr;
  logic        o_skew_err;
  logic        o_sop_err;
  logic [15:0] o_skew_cnt;
  logic [15:0] o_flush_cnt;
  logic [1:0]  o_state;

  int n_checks = 0;
  int n_fail   = 0;

  cpri_rxbuf_align_ctrl dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_rx_rfp    (i_rx_rfp),
    .i_buf_vld   (i_buf_vld),
    .i_buf_sop   (i_buf_sop),
    .o_rd_en     (o_rd_en),
    .o_buf_clr   (o_buf_clr),
    .o_skew_err  (o_skew_err),
    .o_sop_err   (o_sop_err),
    .o_skew_cnt  (o_skew_cnt),
    .o_flush_cnt (o_flush_cnt),
    .o_state     (o_state)
  );

  always #5 i_clk = ~i_clk;

  // One clock edge; sample/drive 2 ns after it.
  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_enable = 1'b0; i_rx_rfp = 1'b0; i_buf_vld = '0; i_buf_sop = '0;
    step(); step();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_enable = 1'b1; i_rx_rfp = 1'b0; i_buf_vld = 8'hFF; i_buf_sop = '0;
    step(); step();
    n_checks++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", o_state); end
    n_checks++; if (o_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %0b want 0", o_rd_en); end
    n_checks++; if (o_buf_clr !== 1'b0) begin n_fail++; $display("FAIL reset_buf_clr: got %0b want 0", o_buf_clr); end
    n_checks++; if (o_skew_err !== 1'b0) begin n_fail++; $display("FAIL reset_skew_err: got %0b want 0", o_skew_err); end
    n_checks++; if (o_sop_err !== 1'b0) begin n_fail++; $display("FAIL reset_sop_err: got %0b want 0", o_sop_err); end
    n_checks++; if (o_skew_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_skew_cnt: got %0d want 0", o_skew_cnt); end
    n_checks++; if (o_flush_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_flush_cnt: got %0d want 0", o_flush_cnt); end
    i_reset = 1'b0; i_enable = 1'b0; i_buf_vld = '0;
  endtask

  task automatic test_all_rise();
    do_reset();
    i_enable = 1'b1; i_buf_vld = 8'hFF;
    step();
    n_checks++; if (o_state !== 2'd1) begin n_fail++; $display("FAIL all_rise_wait: got %0d want 1", o_state); end
    n_checks++; if (o_rd_en !== 1'b0) begin n_fail++; $display("FAIL all_rise_rd_wait: got %0b want 0", o_rd_en); end
    step();
    n_checks++; if (o_state !== 2'd2) begin n_fail++; $display("FAIL all_rise_read: got %0d want 2", o_state); end
    n_checks++; if (o_rd_en !== 1'b1) begin n_fail++; $display("FAIL all_rise_rd_en: got %0b want 1", o_rd_en); end
    n_checks++; if (o_skew_cnt !== 16'd0) begin n_fail++; $display("FAIL all_rise_skew: got %0d want 0", o_skew_cnt); end
    i_buf_vld = 8'h7F; #1;
    n_checks++; if (o_rd_en !== 1'b0) begin n_fail++; $display("FAIL vld_drop_rd_en: got %0b want 0", o_rd_en); end
    step();
    n_checks++; if (o_state !== 2'd1) begin n_fail++; $display("FAIL vld_drop_state: got %0d want 1", o_state); end
  endtask

  task automatic test_skew_100();
    do_reset();
    i_enable = 1'b1;
    step();
    i_buf_vld = 8'h01;
    repeat (100) step();
    i_buf_vld = 8'hFF;
    step();
    n_checks++; if (o_state !== 2'd2) begin n_fail++; $display("FAIL skew100_state: got %0d want 2", o_state); end
    n_checks++; if (o_skew_cnt !== 16'd100) begin n_fail++; $display("FAIL skew100_cnt: got %0d want 100", o_skew_cnt); end
    n_checks++; if (o_skew_err !== 1'b0) begin n_fail++; $display("FAIL skew100_err: got %0b want 0", o_skew_err); end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    i_enable = 1'b1;
    step();
    i_buf_vld = 8'hF7;
    repeat (12673) step();
    n_checks++; if (o_state !== 2'd1) begin n_fail++; $display("FAIL ovf_not_yet: got %0d want 1", o_state); end
    // Frame pulse coincides with the overflow cycle: still one flush entry.
    i_rx_rfp = 1'b1;
    step();
    i_rx_rfp = 1'b0;
    n_checks++; if (o_state !== 2'd3) begin n_fail++; $display("FAIL ovf_flush: got %0d want 3", o_state); end
    n_checks++; if (o_skew_err !== 1'b1) begin n_fail++; $display("FAIL ovf_skew_err: got %0b want 1", o_skew_err); end
    n_checks++; if (o_flush_cnt !== 16'd1) begin n_fail++; $display("FAIL ovf_flush_cnt: got %0d want 1", o_flush_cnt); end
    n_checks++; if (o_rd_en !== 1'b0) begin n_fail++; $display("FAIL ovf_rd_en: got %0b want 0", o_rd_en); end
    n = 0;
    while (o_buf_clr === 1'b1 && n < 40) begin n++; step(); end
    n_checks++; if (n !== 8) begin n_fail++; $display("FAIL ovf_clr_len: got %0d want 8", n); end
    n_checks++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL ovf_to_idle: got %0d want 0", o_state); end
    n_checks++; if (o_skew_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", o_skew_err); end
    step();
    n_checks++; if (o_skew_err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_clear: got %0b want 0", o_skew_err); end
    n_checks++; if (o_state !== 2'd1) begin n_fail++; $display("FAIL ovf_rewait: got %0d want 1", o_state); end
  endtask

  task automatic test_rfp_restart();
    int n;
    do_reset();
    i_enable = 1'b1; i_buf_vld = 8'hFF;
    step(); step();
    i_rx_rfp = 1'b1;
    step();
    i_rx_rfp = 1'b0;
    n_checks++; if (o_state !== 2'd3) begin n_fail++; $display("FAIL rfp_flush: got %0d want 3", o_state); end
    n = 0;
    while (o_buf_clr === 1'b1 && n < 40) begin
      n++;
      i_rx_rfp = (n == 6);
      step();
    end
    i_rx_rfp = 1'b0;
    n_checks++; if (n !== 13) begin n_fail++; $display("FAIL rfp_clr_len: got %0d want 13", n); end
    n_checks++; if (o_flush_cnt !== 16'd1) begin n_fail++; $display("FAIL rfp_flush_cnt: got %0d want 1", o_flush_cnt); end
  endtask

  task automatic test_sop();
    do_reset();
    i_enable = 1'b1; i_buf_vld = 8'hFF;
    step(); step();
    i_buf_sop = 8'hFF;
    step();
    n_checks++; if (o_state !== 2'd2) begin n_fail++; $display("FAIL sop_all_ones_state: got %0d want 2", o_state); end
    n_checks++; if (o_sop_err !== 1'b0) begin n_fail++; $display("FAIL sop_all_ones_err: got %0b want 0", o_sop_err); end
    i_buf_sop = 8'h0F;
    step();
    i_buf_sop = 8'h00;
`ifdef CPRI_RXBUF_SOP_CHECK_EN
    n_checks++; if (o_state !== 2'd3) begin n_fail++; $display("FAIL sop_mis_state: got %0d want 3", o_state); end
    n_checks++; if (o_sop_err !== 1'b1) begin n_fail++; $display("FAIL sop_mis_err: got %0b want 1", o_sop_err); end
`else
    n_checks++; if (o_state !== 2'd2) begin n_fail++; $display("FAIL sop_mis_state: got %0d want 2", o_state); end
    n_checks++; if (o_sop_err !== 1'b0) begin n_fail++; $display("FAIL sop_mis_err: got %0b want 0", o_sop_err); end
`endif
  endtask

  task automatic test_enable_drop();
    int n;
    do_reset();
    i_enable = 1'b1; i_buf_vld = 8'hFF;
    step(); step();
    i_enable = 1'b0; #1;
    n_checks++; if (o_rd_en !== 1'b0) begin n_fail++; $display("FAIL en_drop_rd_en: got %0b want 0", o_rd_en); end
    step();
    n_checks++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL en_drop_idle: got %0d want 0", o_state); end
    i_enable = 1'b1;
    step(); step();
    i_rx_rfp = 1'b1;
    step();
    i_rx_rfp = 1'b0; i_enable = 1'b0;
    n = 0;
    while (o_buf_clr === 1'b1 && n < 40) begin n++; step(); end
    n_checks++; if (n !== 8) begin n_fail++; $display("FAIL en_drop_flush_len: got %0d want 8", n); end
    n_checks++; if (o_flush_cnt !== 16'd1) begin n_fail++; $display("FAIL en_drop_flush_cnt: got %0d want 1", o_flush_cnt); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    i_enable = 1'b1; i_buf_vld = 8'hFF;
    step(); step();
    i_rx_rfp = 1'b1;
    step();
    i_rx_rfp = 1'b0;
    step(); step(); step();
    n_checks++; if (o_buf_clr !== 1'b1) begin n_fail++; $display("FAIL mid_flush_clr: got %0b want 1", o_buf_clr); end
    i_reset = 1'b1;
    step();
    i_reset = 1'b0; i_enable = 1'b0;
    n_checks++; if (o_buf_clr !== 1'b0) begin n_fail++; $display("FAIL mid_flush_abort: got %0b want 0", o_buf_clr); end
    n_checks++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL mid_flush_state: got %0d want 0", o_state); end
    n_checks++; if (o_flush_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_flush_cnt: got %0d want 0", o_flush_cnt); end
    n_checks++; if (o_skew_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_flush_skew: got %0d want 0", o_skew_cnt); end
  endtask

  initial begin
    test_reset();
    test_all_rise();
    test_skew_100();
    test_overflow();
    test_rfp_restart();
    test_sop();
    test_enable_drop();
    test_reset_mid_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
